// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: bypass resolution, op1/op2 select, valid/ready output register.
// Optional forwarding statistics counters enabled with ALU_OPERAND_STAGE_STATS_EN.
module alu_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_BYPASS = 3,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [REG_ADDR_W-1:0]            rs1_addr,
  input  logic [REG_ADDR_W-1:0]            rs2_addr,
  input  logic [XLEN-1:0]                  rs1_data,
  input  logic [XLEN-1:0]                  rs2_data,
  input  logic [XLEN-1:0]                  immediate,
  input  logic [XLEN-1:0]                  pc,
  input  logic [1:0]                       alu_op1_src,
  input  logic                             alu_op2_src,
  input  logic                             flush,
  input  logic [NUM_BYPASS-1:0]            byp_valid,
  input  logic [NUM_BYPASS*REG_ADDR_W-1:0] byp_rd,
  input  logic [NUM_BYPASS*XLEN-1:0]       byp_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  alu_op1,
  output logic [XLEN-1:0]                  alu_op2,
  output logic [XLEN-1:0]                  store_data
`ifdef ALU_OPERAND_STAGE_STATS_EN
  ,
  output logic [31:0]                      fwd_count_rs1,
  output logic [31:0]                      fwd_count_rs2
`endif
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_op1_q, alu_op1_d;
  logic [XLEN-1:0] alu_op2_q, alu_op2_d;
  logic [XLEN-1:0] store_data_q, store_data_d;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            hit_rs1, hit_rs2;
  logic [XLEN-1:0] op1_sel, op2_sel;
  logic            load;

  // Scan youngest-first; the first hit wins and later (older) sources are ignored.
  always_comb begin
    fwd_rs1 = rs1_data;
    fwd_rs2 = rs2_data;
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    for (int unsigned i = 0; i < NUM_BYPASS; i++) begin
      if (!hit_rs1 && byp_valid[i] && (rs1_addr != '0) &&
          (byp_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs1_addr)) begin
        fwd_rs1 = byp_data[i*XLEN +: XLEN];
        hit_rs1 = 1'b1;
      end
      if (!hit_rs2 && byp_valid[i] && (rs2_addr != '0) &&
          (byp_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs2_addr)) begin
        fwd_rs2 = byp_data[i*XLEN +: XLEN];
        hit_rs2 = 1'b1;
      end
    end
  end

  always_comb begin
    case (alu_op1_src)
      2'd0:    op1_sel = fwd_rs1;
      2'd1:    op1_sel = pc;
      default: op1_sel = '0;
    endcase
    op2_sel = alu_op2_src ? immediate : fwd_rs2;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    store_data_d = store_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d  = 1'b1;
      alu_op1_d    = op1_sel;
      alu_op2_d    = op2_sel;
      store_data_d = fwd_rs2;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      store_data_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      store_data_q <= store_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign store_data = store_data_q;

`ifdef ALU_OPERAND_STAGE_STATS_EN
  logic [31:0] fwd_count_rs1_q, fwd_count_rs1_d;
  logic [31:0] fwd_count_rs2_q, fwd_count_rs2_d;

  always_comb begin
    fwd_count_rs1_d = fwd_count_rs1_q;
    fwd_count_rs2_d = fwd_count_rs2_q;
    if (load && hit_rs1 && (fwd_count_rs1_q != '1)) fwd_count_rs1_d = fwd_count_rs1_q + 32'd1;
    if (load && hit_rs2 && (fwd_count_rs2_q != '1)) fwd_count_rs2_d = fwd_count_rs2_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_count_rs1_q <= '0;
      fwd_count_rs2_q <= '0;
    end else begin
      fwd_count_rs1_q <= fwd_count_rs1_d;
      fwd_count_rs2_q <= fwd_count_rs2_d;
    end
  end

  assign fwd_count_rs1 = fwd_count_rs1_q;
  assign fwd_count_rs2 = fwd_count_rs2_q;
`endif

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered ALU operand stage sitting between decode/register-read and execute.
- Resolves rs1/rs2 through a parametrised bypass network, then selects op1 from {rs1, pc, zero} and op2 from {rs2, immediate}.
- Captures both operands, plus forwarded rs2 as store data, into an output register with a valid/ready handshake and flush.
- Replaces the purely combinational operand mux, adding forwarding, stall and flush.

Parameters:
- XLEN, 32, datapath width.
- NUM_BYPASS, 3, number of forwarding sources; index 0 is youngest (EX), highest index is oldest (WB).
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- rs1_addr  in  REG_ADDR_W  source 1 index
- rs2_addr  in  REG_ADDR_W  source 2 index
- rs1_data  in  XLEN  register file read 1
- rs2_data  in  XLEN  register file read 2
- immediate  in  XLEN  decoded immediate
- pc  in  XLEN  PC of this instruction (not PC+4)
- alu_op1_src  in  2  0=rs1, 1=pc (AUIPC), 2=zero (LUI), 3=reserved
- alu_op2_src  in  1  0=rs2, 1=immediate
- flush  in  1  kill the held instruction and any incoming one
- byp_valid  in  NUM_BYPASS  source i carries a valid result
- byp_rd  in  NUM_BYPASS*REG_ADDR_W  destination index per source, packed with i at LSBs
- byp_data  in  NUM_BYPASS*XLEN  result per source, packed
- out_valid  out  1  registered operands valid
- out_ready  in  1  execute accepts
- alu_op1  out  XLEN  registered operand 1
- alu_op2  out  XLEN  registered operand 2
- store_data  out  XLEN  registered forwarded rs2, independent of alu_op2_src

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: out_valid=0, alu_op1=0, alu_op2=0, store_data=0.
- Forwarding, combinational on the input side:
  - fwd_rsN = byp_data[i] for the lowest i with byp_valid[i] && byp_rd[i]==rsN_addr && rsN_addr!=0.
  - Otherwise fwd_rsN = rsN_data.
  - Index 0 is never forwarded; the x0 value always comes from rs*_data.
- Operand select:
  - op1 = fwd_rs1 / pc / 0 / 0 for alu_op1_src 0 / 1 / 2 / 3. The reserved code drives zero and is never X.
  - op2 = fwd_rs2 / immediate.
- Handshake:
  - in_ready = !out_valid || out_ready. The ready path is combinational through out_ready.
  - Load occurs when in_valid && in_ready. At the next edge alu_op1/alu_op2/store_data take the selected values and out_valid=1.
  - When out_valid && out_ready && !(in_valid && in_ready), out_valid clears next edge and data holds its last value.
  - When out_valid && !out_ready, all outputs hold stable. Operands are not re-forwarded while held.
- Latency: 1 cycle from accepted input to out_valid. Throughput is 1 per cycle while out_ready=1.
- Flush:
  - flush=1 forces out_valid=0 at the next edge.
  - Flush takes priority over a simultaneous load. in_ready may still be 1, but the incoming instruction is discarded.
  - Data registers are don't-care after flush; the implementation holds them.
- Reset takes priority over flush and load. Reset mid-stall drops the held instruction.
- Bypass boundary cases:
  - Multiple matching sources: the youngest (lowest index) wins.
  - byp_valid=0 with a matching rd: ignored.
  - rs1_addr==rs2_addr: both resolve identically.

Optional Feature:
- Macro: ALU_OPERAND_STAGE_STATS_EN.
- With the macro defined, add outputs fwd_count_rs1 and fwd_count_rs2, each 32 bits.
  - Each counter increments on every accepted, non-flushed load where that operand was forwarded from any source.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Without the macro, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
1. Reset, then in_valid=1, alu_op1_src=0, alu_op2_src=1, rs1_data=0x10, immediate=0x5, no bypass, out_ready=1 -> one cycle later out_valid=1, alu_op1=0x10, alu_op2=0x5.
2. rs1_addr=3, byp_valid=3'b011, byp_rd[0]=3 data 0xAAAA, byp_rd[1]=3 data 0xBBBB, rs1_data=0x1 -> alu_op1=0xAAAA (youngest wins); repeat with rs1_addr=0 and byp_rd[0]=0 -> alu_op1=rs1_data.
3. alu_op1_src=1, pc=0x8000_0010, imm=0x1000 -> alu_op1=0x80000010. alu_op1_src=2 -> alu_op1=0. alu_op1_src=3 -> alu_op1=0.
4. Store: alu_op2_src=1, rs2_addr=7 forwarded from source 2 with 0xDEAD -> alu_op2=immediate, store_data=0xDEAD.
5. Load A, hold out_ready=0 for 3 cycles while offering B -> in_ready=0, outputs stay A. Raise out_ready -> B appears the next cycle, no loss or duplication.
6. out_valid=1 with flush=1 and a simultaneous valid input -> out_valid=0 next cycle. Reset asserted during a stall -> out_valid=0 and operands=0 next cycle.
